// File: rtl/mem_stage_ctrl_if.sv
// Execute/write-back handshake bundle for the Y86-64 memory-stage controller.
// The master is the execute side; the slave is the controller.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valP;
  logic              instr_valid;
  logic              imem_error;
  logic              out_valid;
  logic [DATA_W-1:0] valM;
  logic [2:0]        stat;
  logic              dmem_error;
  logic              halted;

  modport master (
    output in_valid, icode, valE, valA, valP, instr_valid, imem_error,
    input  in_ready, out_valid, valM, stat, dmem_error, halted
  );

  modport slave (
    input  in_valid, icode, valE, valA, valP, instr_valid, imem_error,
    output in_ready, out_valid, valM, stat, dmem_error, halted
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory-stage controller: decodes icode into a RAM read/write, checks
// the address, waits LATENCY cycles and reports valM plus architectural status.
module mem_stage_ctrl #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  mem_stage_ctrl_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(DEPTH * BYTES);
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(BYTES - 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALT} state_t;

  state_t            state;
  logic [3:0]        latCnt;
  logic              isRead, isWrite, fetchErr, addrFault, doAccess, accept, commit;
  logic [DATA_W-1:0] accAddr, accData;
  logic [2:0]        statDec;
  logic              rdP0, wrP0, faultP0;
  logic [2:0]        statP0;
  logic [AW-1:0]     idxP0;
  logic [DATA_W-1:0] dataP0;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    isRead  = 1'b0;
    isWrite = 1'b0;
    accAddr = bus.valE;
    accData = bus.valA;
    case (bus.icode)
      4'h4: isWrite = 1'b1;
      4'h5: isRead  = 1'b1;
      4'h8: begin isWrite = 1'b1; accData = bus.valP; end
      4'h9: begin isRead  = 1'b1; accAddr = bus.valA; end
      4'hA: isWrite = 1'b1;
      4'hB: begin isRead  = 1'b1; accAddr = bus.valA; end
      default: ;
    endcase
    fetchErr  = bus.imem_error || !bus.instr_valid;
    addrFault = (isRead || isWrite) &&
                ((|(accAddr & ALIGN_MASK)) || (accAddr >= ADDR_LIMIT));
    doAccess  = (isRead || isWrite) && !addrFault && !fetchErr;
    if (bus.imem_error)        statDec = ST_ADR;
    else if (!bus.instr_valid) statDec = ST_INS;
    else if (addrFault)        statDec = ST_ADR;
    else if (bus.icode == 4'h0) statDec = ST_HLT;
    else                       statDec = ST_AOK;
  end

  assign accept = bus.in_valid && bus.in_ready;
  // Non-memory and faulting ops also pass through ACCESS with a zero count,
  // which gives them the fixed one-cycle turnaround.
  assign commit = (state == ACCESS) && (latCnt == 4'd0);

  // ---- stage p0: operands captured at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idxP0  <= accAddr[OFFW +: AW];
      dataP0 <= accData;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wrP0 && !rst) mem[idxP0] <= dataP0;
  end

  // ---- stage p1: FSM and registered write-back outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      latCnt         <= 4'd0;
      rdP0           <= 1'b0;
      wrP0           <= 1'b0;
      faultP0        <= 1'b0;
      statP0         <= ST_AOK;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.valM       <= '0;
      bus.stat       <= ST_AOK;
      bus.dmem_error <= 1'b0;
      bus.halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= ACCESS;
            bus.in_ready <= 1'b0;
            latCnt       <= doAccess ? CNT_LOAD : 4'd0;
            rdP0         <= doAccess && isRead;
            wrP0         <= doAccess && isWrite;
            faultP0      <= addrFault && !fetchErr;
            statP0       <= statDec;
          end
        end
        ACCESS: begin
          if (latCnt == 4'd0) begin
            state          <= DONE;
            bus.out_valid  <= 1'b1;
            bus.valM       <= rdP0 ? mem[idxP0] : '0;
            bus.stat       <= statP0;
            bus.dmem_error <= faultP0;
          end else begin
            latCnt <= latCnt - 4'd1;
          end
        end
        DONE: begin
          bus.out_valid <= 1'b0;
          if (bus.stat != ST_AOK) begin
            state      <= HALT;
            bus.halted <= 1'b1;
          end else begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, multi-cycle corner cases
// and randomized ops checked against a behavioural memory model.
module tb_mem_stage_ctrl;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam logic [63:0] POOL = 64'h400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_W(DATA_W)) bus();
  mem_stage_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] refMem [int];

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] e, a, p;
    logic [63:0] xV;
    logic [2:0]  xS;
    int          xL;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one op, measure accept-to-out_valid latency and sample results.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, a, p,
                       input logic iv, ime,
                       output logic [63:0] gV, output logic [2:0] gS,
                       output logic gD, output int gL);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
    bus.instr_valid = iv; bus.imem_error = ime; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    gL = -1; gV = '0; gS = '0; gD = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin gL = k; break; end
    end
    gV = bus.valM; gS = bus.stat; gD = bus.dmem_error;
    @(posedge clk); #1;
    chk("out_valid_pulse", {63'd0, bus.out_valid}, 64'd0);
    chk("valM_hold", bus.valM, gV);
  endtask

  // Behavioural model: status priority and memory effect from the ISA rules.
  task automatic refOp(input logic [3:0] ic, input logic [63:0] e, a, p,
                       input logic iv, ime, input string tag);
    logic rd, wr, bad, access, gD, eD;
    logic [63:0] addr, gV, eV;
    logic [2:0] gS, eS;
    int gL, eL, idx;
    rd = ic inside {4'h5, 4'h9, 4'hB};
    wr = ic inside {4'h4, 4'h8, 4'hA};
    addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
    bad = (addr % 8 != 0) || (addr >= 64'(DEPTH * 8));
    if (ime)                  eS = 3'd3;
    else if (!iv)             eS = 3'd4;
    else if ((rd || wr) && bad) eS = 3'd3;
    else if (ic == 4'h0)      eS = 3'd2;
    else                      eS = 3'd1;
    access = (rd || wr) && !bad && !ime && iv;
    eL = access ? LATENCY : 1;
    eD = (rd || wr) && bad && !ime && iv;
    idx = int'(addr / 8);
    eV = 64'd0;
    if (access && rd) eV = refMem.exists(idx) ? refMem[idx] : 64'd0;
    if (access && wr) refMem[idx] = (ic == 4'h8) ? p : a;
    issue(ic, e, a, p, iv, ime, gV, gS, gD, gL);
    chk({tag, "_valM"}, gV, eV);
    chk({tag, "_stat"}, {61'd0, gS}, {61'd0, eS});
    chk({tag, "_dmem_error"}, {63'd0, gD}, {63'd0, eD});
    chk({tag, "_latency"}, 64'(gL), 64'(eL));
    chk({tag, "_halted"}, {63'd0, bus.halted}, {63'd0, eS != 3'd1});
    if (eS != 3'd1) doReset();
  endtask

  logic [63:0] gV, d, e, a, p;
  logic [2:0]  gS;
  logic        gD, seen, iv, ime;
  logic [3:0]  ic;
  int          gL, r, off;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.icode = 4'h0; bus.valE = '0; bus.valA = '0;
    bus.valP = '0; bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_valM", bus.valM, 64'd0);
    chk("rst_stat", {61'd0, bus.stat}, 64'd1);
    chk("rst_dmem_error", {63'd0, bus.dmem_error}, 64'd0);
    chk("rst_halted", {63'd0, bus.halted}, 64'd0);
    rst = 1'b0;

    tbl[0]  = '{4'h4, 64'h40,  64'hDEADBEEF, 64'h0,   64'h0,        3'd1, 2};
    tbl[1]  = '{4'h5, 64'h40,  64'h0,        64'h0,   64'hDEADBEEF, 3'd1, 2};
    tbl[2]  = '{4'h8, 64'h1F8, 64'h0,        64'h123, 64'h0,        3'd1, 2};
    tbl[3]  = '{4'h9, 64'h0,   64'h1F8,      64'h0,   64'h123,      3'd1, 2};
    tbl[4]  = '{4'hA, 64'h200, 64'h777,      64'h0,   64'h0,        3'd1, 2};
    tbl[5]  = '{4'hB, 64'h0,   64'h200,      64'h0,   64'h777,      3'd1, 2};
    tbl[6]  = '{4'h6, 64'h55,  64'h0,        64'h0,   64'h0,        3'd1, 1};
    tbl[7]  = '{4'h4, 64'h0,   64'hA5A5,     64'h0,   64'h0,        3'd1, 2};
    tbl[8]  = '{4'h4, 64'h80,  64'h1234,     64'h0,   64'h0,        3'd1, 2};
    tbl[9]  = '{4'h4, 64'h300, 64'h11,       64'h0,   64'h0,        3'd1, 2};
    tbl[10] = '{4'h5, 64'h0,   64'h0,        64'h0,   64'hA5A5,     3'd1, 2};
    tbl[11] = '{4'h1, 64'h8,   64'h0,        64'h0,   64'h0,        3'd1, 1};
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].ic, tbl[i].e, tbl[i].a, tbl[i].p, 1'b1, 1'b0, gV, gS, gD, gL);
      chk($sformatf("vec%0d_valM", i), gV, tbl[i].xV);
      chk($sformatf("vec%0d_stat", i), {61'd0, gS}, {61'd0, tbl[i].xS});
      chk($sformatf("vec%0d_latency", i), 64'(gL), 64'(tbl[i].xL));
      chk($sformatf("vec%0d_dmem_error", i), {63'd0, gD}, 64'd0);
    end

    issue(4'h5, 64'h41, 64'h0, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("misalign_stat", {61'd0, gS}, 64'd3);
    chk("misalign_dmem_error", {63'd0, gD}, 64'd1);
    chk("misalign_valM", gV, 64'd0);
    chk("misalign_latency", 64'(gL), 64'd1);
    chk("misalign_halted", {63'd0, bus.halted}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("misalign_in_ready", {63'd0, bus.in_ready}, 64'd0);
    doReset();

    issue(4'h4, 64'(DEPTH * 8), 64'hBAD, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("range_stat", {61'd0, gS}, 64'd3);
    chk("range_dmem_error", {63'd0, gD}, 64'd1);
    doReset();
    issue(4'h5, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("range_word0_intact", gV, 64'hA5A5);

    issue(4'h4, 64'h300, 64'h99, 64'h0, 1'b0, 1'b0, gV, gS, gD, gL);
    chk("ins_stat", {61'd0, gS}, 64'd4);
    chk("ins_latency", 64'(gL), 64'd1);
    doReset();
    issue(4'h5, 64'h300, 64'h0, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("ins_no_write", gV, 64'h11);

    issue(4'h5, 64'h40, 64'h0, 64'h0, 1'b0, 1'b1, gV, gS, gD, gL);
    chk("imem_stat", {61'd0, gS}, 64'd3);
    chk("imem_latency", 64'(gL), 64'd1);
    chk("imem_valM", gV, 64'd0);
    doReset();

    issue(4'h6, 64'h1, 64'h2, 64'h3, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("opq_stat", {61'd0, gS}, 64'd1);
    chk("opq_valM", gV, 64'd0);
    chk("opq_latency", 64'(gL), 64'd1);
    issue(4'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("hlt_stat", {61'd0, gS}, 64'd2);
    chk("hlt_halted", {63'd0, bus.halted}, 64'd1);
    seen = 1'b0;
    bus.icode = 4'h6; bus.in_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("hlt_ignores_in_valid", {63'd0, seen}, 64'd0);
    chk("hlt_in_ready", {63'd0, bus.in_ready}, 64'd0);
    doReset();

    // Reset during ACCESS of a write must abandon it.
    bus.icode = 4'h4; bus.valE = 64'h80; bus.valA = 64'h55;
    bus.instr_valid = 1'b1; bus.imem_error = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("abort_stat", {61'd0, bus.stat}, 64'd1);
    chk("abort_valM", bus.valM, 64'd0);
    chk("abort_halted", {63'd0, bus.halted}, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", {63'd0, seen}, 64'd0);
    issue(4'h5, 64'h80, 64'h0, 64'h0, 1'b1, 1'b0, gV, gS, gD, gL);
    chk("abort_no_write", gV, 64'h1234);

    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      refOp(4'h4, POOL + 64'(i * 8), d, 64'h0, 1'b1, 1'b0, "fill");
    end
    for (int n = 0; n < 150; n++) begin
      ic  = 4'($urandom_range(1, 15));
      e   = POOL + 64'($urandom_range(0, 15) * 8);
      a   = POOL + 64'($urandom_range(0, 15) * 8);
      p   = {$urandom, $urandom};
      iv  = 1'b1;
      ime = 1'b0;
      if (!(ic inside {4'h9, 4'hB}) && $urandom_range(0, 1) == 1) a = {$urandom, $urandom};
      r = $urandom_range(0, 15);
      case (r)
        0: begin off = $urandom_range(1, 7); e = e + 64'(off); a = a + 64'(off); end
        1: begin e = 64'(DEPTH * 8) + (e - POOL); a = 64'(DEPTH * 8) + (a - POOL); end
        2: iv = 1'b0;
        3: begin ime = 1'b1; iv = 1'($urandom_range(0, 1)); end
        4: ic = 4'h0;
        default: ;
      endcase
      refOp(ic, e, a, p, iv, ime, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
